// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU operation codes and carry-chain slicing helper
package alu_pkg;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_ADC, OP_SBC} op_t;
  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction
endpackage

// File: rtl/add_slice.sv
// add_slice: combinational SW-bit adder slice with carry-in, carry-out and carry into its MSB
module add_slice #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] sum,
  output logic          cout,
  output logic          cmsb
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};
  // sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out of the MSB bits
  assign cmsb = a[SW-1] ^ b[SW-1] ^ sum[SW-1];
endmodule

// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: valid/ready pipelined add/sub/adc/sbc, carry chain cut into STAGES slices
module pipelined_add_sub
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in_0,
  input  logic [WIDTH-1:0] data_in_1,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);
  localparam int SW = slice_width(WIDTH, STAGES);
  localparam int L  = STAGES - 1;
  if (STAGES < 1 || STAGES > WIDTH || WIDTH % STAGES != 0) begin : g_bad_cfg
    $error("pipelined_add_sub: WIDTH must be a multiple of STAGES");
  end
  op_t op_e;
  logic en, cin_eff;
  logic [WIDTH-1:0] b_eff;
  logic [STAGES-1:0][WIDTH-1:0] a_c, b_c, s_c;
  logic [STAGES-1:0] c_c, v_c, o_c;
  assign op_e     = op_t'(op);
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign b_eff    = (op_e == OP_SUB || op_e == OP_SBC) ? ~data_in_1 : data_in_1;
  assign cin_eff  = op_e == OP_ADD ? 1'b0 : op_e == OP_SUB ? 1'b1 : carry_in;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [WIDTH-1:0] a_i, b_i, s_i, s_o;
    logic c_i, v_i, o_i, co, cm;
    logic [SW-1:0] sl;
    if (k == 0) begin : g_src
      assign a_i = data_in_0;
      assign b_i = b_eff;
      assign s_i = '0;
      assign c_i = cin_eff;
      assign v_i = in_valid;
      assign o_i = 1'b0;
    end else begin : g_src
      // skew registers: pending upper operand slices ride along with finished lower sum slices
      logic [WIDTH-1:0] a_q, b_q, s_q;
      logic c_q, v_q, o_q;
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          {a_q, b_q, s_q, c_q, v_q, o_q} <= '0;
        end else if (en) begin
          v_q <= v_c[k-1];
          if (v_c[k-1]) begin
            a_q <= a_c[k-1];
            b_q <= b_c[k-1];
            s_q <= s_c[k-1];
            c_q <= c_c[k-1];
            o_q <= o_c[k-1];
          end
        end
      end
      assign a_i = a_q;
      assign b_i = b_q;
      assign s_i = s_q;
      assign c_i = c_q;
      assign v_i = v_q;
      assign o_i = o_q;
    end
    add_slice #(.SW(SW)) u_slice (
      .a   (SW'(a_i >> (k * SW))),
      .b   (SW'(b_i >> (k * SW))),
      .cin (c_i),
      .sum (sl),
      .cout(co),
      .cmsb(cm)
    );
    always_comb begin
      s_o = s_i;
      s_o[k*SW +: SW] = sl;
    end
    assign a_c[k] = a_i;
    assign b_c[k] = b_i;
    assign s_c[k] = s_o;
    assign c_c[k] = co;
    assign v_c[k] = v_i;
    assign o_c[k] = (k == L) ? (cm ^ co) : o_i;
  end
  // result fields only load on a valid op so bubbles never disturb the visible outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      {out_valid, data_out, carry_out, overflow, zero} <= '0;
    end else if (en) begin
      out_valid <= v_c[L];
      if (v_c[L]) begin
        data_out  <= s_c[L];
        carry_out <= c_c[L];
        overflow  <= o_c[L];
        zero      <= s_c[L] == '0;
      end
    end
  end
endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb_pipelined_add_sub: directed self-checking bench for pipelined_add_sub (WIDTH=32, STAGES=4)
module tb_pipelined_add_sub;
  import alu_pkg::*;
  logic clock, reset, in_valid, in_ready, carry_in, out_valid, out_ready;
  logic [1:0] op;
  logic [31:0] data_in_0, data_in_1, data_out;
  logic carry_out, overflow, zero;
  int total, bad;

  pipelined_add_sub #(.WIDTH(32), .STAGES(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .data_in_0(data_in_0), .data_in_1(data_in_1), .carry_in(carry_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .carry_out(carry_out), .overflow(overflow), .zero(zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input op_t o, input logic [31:0] a, input logic [31:0] b, input logic ci);
    op = o; data_in_0 = a; data_in_1 = b; carry_in = ci; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 2'd0;
    data_in_0 = '0; data_in_1 = '0; carry_in = 1'b0;
    step(2);
    total++;
    if ({out_valid, data_out, carry_out, overflow, zero} !== 36'h0) begin
      bad++; $display("FAIL reset_outputs: got %h want %h", {out_valid, data_out, carry_out, overflow, zero}, 36'h0);
    end
    reset = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tick();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_idle_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_add_wrap();
    send(OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0);
    for (int i = 1; i < 4; i++) begin
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_early edge %0d: got %b want 0", i, out_valid); end
      tick();
    end
    total++;
    if ({out_valid, data_out, carry_out, overflow, zero} !== {1'b1, 32'h0, 3'b101}) begin
      bad++; $display("FAIL add_wrap: got %h want %h", {out_valid, data_out, carry_out, overflow, zero}, {1'b1, 32'h0, 3'b101});
    end
    tick();
    total++;
    if ({out_valid, data_out, zero} !== {1'b0, 32'h0, 1'b1}) begin
      bad++; $display("FAIL bubble_hold: got %h want %h", {out_valid, data_out, zero}, {1'b0, 32'h0, 1'b1});
    end
  endtask

  task automatic test_add_overflow();
    send(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0);
    send(OP_ADD, 32'h1, 32'h1, 1'b1);
    step(2);
    total++;
    if ({out_valid, data_out, carry_out, overflow, zero} !== {1'b1, 32'h8000_0000, 3'b010}) begin
      bad++; $display("FAIL add_overflow: got %h want %h", {out_valid, data_out, carry_out, overflow, zero}, {1'b1, 32'h8000_0000, 3'b010});
    end
    tick();
    total++;
    if ({out_valid, data_out, carry_out, overflow, zero} !== {1'b1, 32'h2, 3'b000}) begin
      bad++; $display("FAIL add_ignores_cin: got %h want %h", {out_valid, data_out, carry_out, overflow, zero}, {1'b1, 32'h2, 3'b000});
    end
    tick();
  endtask

  task automatic test_sub();
    send(OP_SUB, 32'h5, 32'h7, 1'b0);
    send(OP_SUB, 32'h8000_0000, 32'h1, 1'b0);
    step(2);
    total++;
    if ({out_valid, data_out, carry_out, overflow, zero} !== {1'b1, 32'hFFFF_FFFE, 3'b000}) begin
      bad++; $display("FAIL sub_borrow: got %h want %h", {out_valid, data_out, carry_out, overflow, zero}, {1'b1, 32'hFFFF_FFFE, 3'b000});
    end
    tick();
    total++;
    if ({out_valid, data_out, carry_out, overflow, zero} !== {1'b1, 32'h7FFF_FFFF, 3'b110}) begin
      bad++; $display("FAIL sub_overflow: got %h want %h", {out_valid, data_out, carry_out, overflow, zero}, {1'b1, 32'h7FFF_FFFF, 3'b110});
    end
    tick();
  endtask

  task automatic test_adc();
    send(OP_ADC, 32'h0000_00FF, 32'h0, 1'b1);
    send(OP_ADC, 32'h00FF_FFFF, 32'h0, 1'b1);
    step(2);
    total++;
    if ({out_valid, data_out, carry_out, overflow, zero} !== {1'b1, 32'h0000_0100, 3'b000}) begin
      bad++; $display("FAIL adc_slice0_carry: got %h want %h", {out_valid, data_out, carry_out, overflow, zero}, {1'b1, 32'h0000_0100, 3'b000});
    end
    tick();
    total++;
    if ({out_valid, data_out, carry_out, overflow, zero} !== {1'b1, 32'h0100_0000, 3'b000}) begin
      bad++; $display("FAIL adc_slice2_carry: got %h want %h", {out_valid, data_out, carry_out, overflow, zero}, {1'b1, 32'h0100_0000, 3'b000});
    end
    tick();
  endtask

  task automatic test_sbc();
    send(OP_SBC, 32'hA, 32'h3, 1'b0);
    send(OP_SBC, 32'h3, 32'h3, 1'b1);
    step(2);
    total++;
    if ({out_valid, data_out, carry_out, overflow, zero} !== {1'b1, 32'h6, 3'b100}) begin
      bad++; $display("FAIL sbc_borrow_in: got %h want %h", {out_valid, data_out, carry_out, overflow, zero}, {1'b1, 32'h6, 3'b100});
    end
    tick();
    total++;
    if ({out_valid, data_out, carry_out, overflow, zero} !== {1'b1, 32'h0, 3'b101}) begin
      bad++; $display("FAIL sbc_zero: got %h want %h", {out_valid, data_out, carry_out, overflow, zero}, {1'b1, 32'h0, 3'b101});
    end
    tick();
  endtask

  task automatic test_backpressure();
    int i, k, stall;
    logic started, accepted;
    i = 1; k = 0; stall = 0; started = 1'b0;
    op = OP_ADD; carry_in = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid === 1'b1 && !started) begin started = 1'b1; stall = 5; end
      out_ready = (stall == 0);
      in_valid = (i <= 8);
      data_in_0 = 32'(i);
      data_in_1 = 32'(i);
      #1;
      if (stall > 0) begin
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
        total++;
        if ({out_valid, data_out} !== {1'b1, 32'h2}) begin
          bad++; $display("FAIL stall_hold: got %h want %h", {out_valid, data_out}, {1'b1, 32'h2});
        end
        stall--;
      end else if (out_valid === 1'b1) begin
        total++;
        if (k >= 8) begin
          bad++; $display("FAIL stream_extra: got %h want no result", data_out);
        end else if (data_out !== 32'(2 * (k + 1))) begin
          bad++; $display("FAIL stream_order: got %h want %h", data_out, 32'(2 * (k + 1)));
        end
        k++;
      end
      accepted = in_valid && in_ready;
      tick();
      if (accepted) i++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    total++;
    if (k !== 8) begin bad++; $display("FAIL stream_count: got %0d want 8", k); end
  endtask

  task automatic test_reset_mid();
    send(OP_ADD, 32'hA, 32'hA, 1'b0);
    send(OP_ADD, 32'hB, 32'hB, 1'b0);
    send(OP_ADD, 32'hC, 32'hC, 1'b0);
    send(OP_ADD, 32'hD, 32'hD, 1'b0);
    total++;
    if ({out_valid, data_out} !== {1'b1, 32'h14}) begin
      bad++; $display("FAIL pre_reset_result: got %h want %h", {out_valid, data_out}, {1'b1, 32'h14});
    end
    #3 reset = 1'b1;
    #1;
    total++;
    if ({out_valid, data_out, carry_out, overflow, zero} !== 36'h0) begin
      bad++; $display("FAIL async_reset: got %h want %h", {out_valid, data_out, carry_out, overflow, zero}, 36'h0);
    end
    tick();
    reset = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    for (int c = 0; c < 8; c++) begin
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL ghost_result: got %h want no result", data_out); end
      tick();
    end
    send(OP_ADD, 32'h1, 32'h1, 1'b0);
    step(3);
    total++;
    if ({out_valid, data_out, carry_out, overflow, zero} !== {1'b1, 32'h2, 3'b000}) begin
      bad++; $display("FAIL post_reset_add: got %h want %h", {out_valid, data_out, carry_out, overflow, zero}, {1'b1, 32'h2, 3'b000});
    end
    tick();
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_add_wrap();
    test_add_overflow();
    test_sub();
    test_adc();
    test_sbc();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
